// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: Q8.8 (x, y) -> Q9.7 angle in degrees and Q8.8 magnitude.
// Optional macro CORDIC_VEC_GAIN_COMP_EN scales the magnitude by 155/256 to remove the CORDIC gain.
module cordic_vector #(
  parameter int unsigned ITER = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] angle_out,
  output logic [15:0] mag_out,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

  state_e             state_q, state_d;
  logic signed [17:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic        [15:0] angle_q, angle_d, mag_q, mag_d;
  logic               ovf_q, ovf_d, done_q, done_d;

  logic signed [17:0] x_ext, y_ext, x_sh, y_sh, atan_i;
  logic signed [25:0] mag_full;

  assign x_ext = $signed({{2{x_in[15]}}, x_in});
  assign y_ext = $signed({{2{y_in[15]}}, y_in});
  assign x_sh  = x_q >>> cnt_q;
  assign y_sh  = y_q >>> cnt_q;

  // atan(2^-i) in degrees, Q10.8
  always_comb begin
    atan_i = '0;
    case (cnt_q)
      4'd0:    atan_i = 18'sh02D00;
      4'd1:    atan_i = 18'sh01A91;
      4'd2:    atan_i = 18'sh00E09;
      4'd3:    atan_i = 18'sh00720;
      4'd4:    atan_i = 18'sh00394;
      4'd5:    atan_i = 18'sh001CA;
      4'd6:    atan_i = 18'sh000E5;
      4'd7:    atan_i = 18'sh00073;
      4'd8:    atan_i = 18'sh00039;
      4'd9:    atan_i = 18'sh0001D;
      4'd10:   atan_i = 18'sh0000E;
      4'd11:   atan_i = 18'sh00007;
      default: atan_i = '0;
    endcase
  end

  always_comb begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
    mag_full = ($signed({{8{x_q[17]}}, x_q}) * 26'sd155) >>> 8;
`else
    mag_full = $signed({{8{x_q[17]}}, x_q});
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          zero_d  = (x_in == 16'h0000) && (y_in == 16'h0000);
          // Fold the left half-plane onto the right so the iterations always converge.
          if (x_in[15]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = y_in[15] ? -18'sd46080 : 18'sd46080;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end
        end
      end
      StRun: begin
        if (!y_q[17]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER - 1)) state_d = StOut;
      end
      StOut: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (zero_q) begin
          angle_d = '0;
          mag_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          angle_d = 16'((z_q + 18'sd1) >>> 1);
          if (mag_full > 26'sd32767) begin
            mag_d = 16'h7FFF;
            ovf_d = 1'b1;
          end else if (mag_full < 26'sd0) begin
            mag_d = '0;
            ovf_d = 1'b0;
          end else begin
            mag_d = mag_full[15:0];
            ovf_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign angle_out = angle_q;
  assign mag_out   = mag_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: an integer algorithmic model plus real-valued atan2/sqrt
// sanity checks, handshake timing, back-to-back requests and mid-operation reset.
module tb_cordic_vector;

  localparam int ITER = 8;
  localparam int ATAB [12] = '{32'h2D00, 32'h1A91, 32'h0E09, 32'h0720, 32'h0394, 32'h01CA,
                               32'h00E5, 32'h0073, 32'h0039, 32'h001D, 32'h000E, 32'h0007};

  logic        clk, rst_n, start;
  logic [15:0] x_in, y_in;
  logic        busy, done, ovf;
  logic [15:0] angle_out, mag_out;

  int  n_checks = 0;
  int  n_fail   = 0;
  real kn;

  cordic_vector #(.ITER(ITER)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .busy     (busy),
    .done     (done),
    .angle_out(angle_out),
    .mag_out  (mag_out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Straight-line evaluation of the vectoring algorithm on plain integers.
  function automatic void model(input logic [15:0] xi, input logic [15:0] yi,
                                output logic [15:0] ea, output logic [15:0] em,
                                output logic eo);
    int x, y, z, xn, m;
    x = int'($signed(xi));
    y = int'($signed(yi));
    z = 0;
    if (x < 0) begin
      z = (y >= 0) ? 180 * 256 : -180 * 256;
      x = -x;
      y = -y;
    end
    for (int i = 0; i < ITER; i++) begin
      if (y >= 0) begin
        xn = x + (y >>> i);
        y  = y - (x >>> i);
        z  = z + ATAB[i];
      end else begin
        xn = x - (y >>> i);
        y  = y + (x >>> i);
        z  = z - ATAB[i];
      end
      x = xn;
    end
`ifdef CORDIC_VEC_GAIN_COMP_EN
    m = (x * 155) >>> 8;
`else
    m = x;
`endif
    eo = (m > 32767);
    if (eo) m = 32767;
    ea = 16'((z + 1) >>> 1);
    em = 16'(m);
    if (xi == 16'h0000 && yi == 16'h0000) begin
      ea = '0;
      em = '0;
      eo = 1'b0;
    end
  endfunction

  // One request; operands are scrambled right after capture. lat = 0 means no done seen.
  task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, output logic [15:0] a,
                        output logic [15:0] m, output logic o, output int lat);
    @(negedge clk);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = 16'($urandom);
    y_in  = 16'($urandom);
    lat = 0;
    a   = '0;
    m   = '0;
    o   = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        a   = angle_out;
        m   = mag_out;
        o   = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    n_checks++;
    if (angle_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_angle got %h exp 0000", angle_out);
    end
    n_checks++;
    if (mag_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mag got %h exp 0000", mag_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_handshake;
    logic [15:0] ea, em;
    logic        eo;
    int          lat;
    model(16'h0100, 16'h0000, ea, em, eo);
    @(negedge clk);
    x_in  = 16'h0100;
    y_in  = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_busy_after_start got %b exp 1", busy); end
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = c; break; end
    end
    n_checks++;
    if (lat != ITER + 1) begin n_fail++; $display("FAIL hs_latency got %0d exp %0d", lat, ITER + 1); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_busy_at_done got %b exp 0", busy); end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL hs_done_pulse got %b exp 0", done); end
    n_checks++;
    if (angle_out !== ea || mag_out !== em || ovf !== eo) begin
      n_fail++;
      $display("FAIL hs_hold got %h/%h/%b exp %h/%h/%b", angle_out, mag_out, ovf, ea, em, eo);
    end
  endtask

  task automatic test_directed;
    logic [15:0] xs [9] = '{16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'h0000,
                            16'h7F00, 16'h8000, 16'h0000};
    logic [15:0] ys [9] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0000, 16'hFFFF, 16'h0000,
                            16'h7F00, 16'h8000, 16'h8000};
    logic [15:0] a, m, ea, em;
    logic        o, eo;
    int          lat;
    real         xr, yr, ai, mi, d, mtol;
    for (int k = 0; k < 9; k++) begin
      model(xs[k], ys[k], ea, em, eo);
      run_op(xs[k], ys[k], a, m, o, lat);
      n_checks++;
      if (lat != ITER + 1) begin
        n_fail++; $display("FAIL dir%0d_latency got %0d exp %0d", k, lat, ITER + 1);
      end
      n_checks++;
      if (a !== ea || m !== em || o !== eo) begin
        n_fail++;
        $display("FAIL dir%0d_exact got %h/%h/%b exp %h/%h/%b", k, a, m, o, ea, em, eo);
      end
      xr = real'($signed(xs[k]));
      yr = real'($signed(ys[k]));
      ai = $atan2(yr, xr) * 180.0 / 3.14159265358979 * 128.0;
      mi = $sqrt(xr * xr + yr * yr);
`ifdef CORDIC_VEC_GAIN_COMP_EN
      mtol = 3.0;
`else
      mi   = mi * kn;
      mtol = 8.0;
`endif
      if (mi > 32767.0) mi = 32767.0;
      d = real'($signed(a)) - ai;
      n_checks++;
      if (d > 64.0 || d < -64.0) begin
        n_fail++; $display("FAIL dir%0d_angle_tol got %h exp ~%0.1f", k, a, ai);
      end
      d = real'(m) - mi;
      n_checks++;
      if (d > mtol || d < -mtol) begin
        n_fail++; $display("FAIL dir%0d_mag_tol got %h exp ~%0.1f", k, m, mi);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] xv, yv, a, m, ea, em;
    logic        o, eo;
    int          lat;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) begin
        xv = 16'($signed(10'($urandom)));
        yv = 16'($signed(10'($urandom)));
      end else begin
        xv = 16'($urandom);
        yv = 16'($urandom);
      end
      model(xv, yv, ea, em, eo);
      run_op(xv, yv, a, m, o, lat);
      n_checks++;
      if (lat != ITER + 1) begin
        n_fail++; $display("FAIL rnd%0d_latency got %0d exp %0d", k, lat, ITER + 1);
      end
      n_checks++;
      if (a !== ea || m !== em || o !== eo) begin
        n_fail++;
        $display("FAIL rnd%0d x=%h y=%h got %h/%h/%b exp %h/%h/%b", k, xv, yv, a, m, o, ea, em, eo);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ea, em, ea2, em2;
    logic        eo, eo2;
    int          ndone, first, second;
    model(16'h0100, 16'h0100, ea, em, eo);
    model(16'hFF00, 16'h0080, ea2, em2, eo2);
    ndone  = 0;
    first  = 0;
    second = 0;
    @(negedge clk);
    x_in  = 16'h0100;
    y_in  = 16'h0100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      start = (e == 3) || (done && ndone == 1);
      if (done && ndone == 1) begin
        x_in = 16'hFF00;
        y_in = 16'h0080;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = e;
          n_checks++;
          if (angle_out !== ea || mag_out !== em || ovf !== eo) begin
            n_fail++;
            $display("FAIL b2b_first got %h/%h/%b exp %h/%h/%b", angle_out, mag_out, ovf, ea, em, eo);
          end
        end else if (second == 0) begin
          second = e;
          n_checks++;
          if (angle_out !== ea2 || mag_out !== em2 || ovf !== eo2) begin
            n_fail++;
            $display("FAIL b2b_second got %h/%h/%b exp %h/%h/%b",
                     angle_out, mag_out, ovf, ea2, em2, eo2);
          end
        end
      end
    end
    n_checks++;
    if (ndone != 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", ndone); end
    n_checks++;
    if (first != ITER + 1) begin
      n_fail++; $display("FAIL b2b_first_time got %0d exp %0d", first, ITER + 1);
    end
    n_checks++;
    if (second != 2 * ITER + 3) begin
      n_fail++; $display("FAIL b2b_second_time got %0d exp %0d", second, 2 * ITER + 3);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] a, m, ea, em;
    logic        o, eo;
    int          lat, ndone;
    @(negedge clk);
    x_in  = 16'h0300;
    y_in  = 16'hFE00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_checks++;
    if (angle_out !== 16'h0000 || mag_out !== 16'h0000 || ovf !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got %h/%h/%b/%b exp 0000/0000/0/0", angle_out, mag_out, ovf, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d exp 0", ndone); end
    model(16'h0300, 16'hFE00, ea, em, eo);
    run_op(16'h0300, 16'hFE00, a, m, o, lat);
    n_checks++;
    if (lat != ITER + 1) begin
      n_fail++; $display("FAIL rstmid_after_latency got %0d exp %0d", lat, ITER + 1);
    end
    n_checks++;
    if (a !== ea || m !== em || o !== eo) begin
      n_fail++;
      $display("FAIL rstmid_after got %h/%h/%b exp %h/%h/%b", a, m, o, ea, em, eo);
    end
  endtask

  initial begin
    real p;
    kn = 1.0;
    p  = 1.0;
    for (int i = 0; i < ITER; i++) begin
      kn = kn * $sqrt(1.0 + p);
      p  = p / 4.0;
    end
    test_reset();
    test_handshake();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
